rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter with a registered grant.
- It sits directly upstream of the team's 8-to-3 encoder. grant[7:0] drives the encoder's one-hot data input; grant_valid drives its enable.
- The block guarantees that grant is always one-hot or all-zero, so the encoder never sees an illegal code.
- A grant is held until the owner releases, the owner drops its request, or a hold timeout expires.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held before forced revocation (legal range 2 to 256).
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- req  input  8  request vector; bit i = requester i.
- release  input  1  owner done; sampled only while grant_valid=1.
- grant  output  8  registered one-hot grant, or 0 when idle.
- grant_valid  output  1  registered; always equals OR of grant.
- grant_timeout  output  1  one-cycle pulse marking a forced revocation.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - grant=0, grant_valid=0, grant_timeout=0.
  - State=IDLE, ptr=0, hold_cnt=0, owner=0.
- Arbitration function:
  - Search req (after masking) starting at bit ptr, ascending, wrapping 7 to 0.
  - The first set bit wins.
  - Search is combinational; its result is registered.
- State IDLE (grant=0):
  - If req != 0 at a rising edge, the next cycle enters GRANT with grant=onehot(winner) and grant_valid=1.
  - On that edge: owner <= winner, ptr <= (winner+1) mod 8, hold_cnt <= 0.
  - Latency from req sampled to grant is 1 cycle.
  - If req == 0, stay IDLE.
- State GRANT:
  - hold_cnt increments each cycle; it saturates at MAX_HOLD-1 and never wraps.
  - End conditions are evaluated each edge in this priority:
    - (1) release=1.
    - (2) req[owner]=0.
    - (3) hold_cnt == MAX_HOLD-1 (timeout).
  - With no end condition, grant is unchanged regardless of other req activity.
- At an end edge:
  - Arbitrate over req with bit owner masked off, starting from the current ptr.
  - If the result is nonzero, the next cycle shows the new grant directly: back-to-back, no idle gap. Update owner, ptr and hold_cnt as in IDLE.
  - Otherwise the next cycle is IDLE with grant=0 and grant_valid=0.
  - Consequence: the same requester never holds two consecutive grants without at least one idle cycle in between.
- grant_timeout:
  - Asserted for exactly the one cycle following an end edge caused solely by condition (3).
  - It is coincident with the new grant or the idle cycle.
  - If release=1 or req[owner]=0 on the same edge as the timeout, there is no pulse.
- Invariants:
  - grant has zero or one bit set at all times.
  - grant_valid == |grant.
  - The ptr wrap from 7 goes to 0.
- release asserted in IDLE is ignored.

Test Plan:
- Reset, then req=8'b0000_0100, release pulsed after 3 cycles -> grant=8'b0000_0100 one cycle after req, held 3 cycles, then grant=0. ptr=3.
- From reset, req=8'hFF held, release pulsed every cycle -> grant sequence 0x01,0x02,0x04,…,0x80,0x01 (wrap), back-to-back with no gaps.
- req=8'b1000_0001 with ptr=7, no release -> grant=0x80 until timeout. Counting from the first grant cycle, 0x80 is held exactly MAX_HOLD=16 cycles, then grant=0x01 and grant_timeout=1 for one cycle.
- Sole requester req=0x10 never releasing -> timeout after 16 cycles, grant=0 for at least one cycle with grant_timeout=1, then re-grant 0x10.
- release and timeout on the same edge -> no grant_timeout pulse; next grant per round-robin.
- Owner drops req mid-grant (req 0x06 to 0x04 with owner bit 1) -> grant moves to 0x04 the next cycle. Then assert rst mid-grant -> grant, grant_valid and grant_timeout are 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with registered, time-limited grant
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req[7:0]      request vector, bit i = requester i
//   rel           owner done; only looked at while a grant is active
//   grant[7:0]    registered one-hot grant, zero when idle
//   grant_valid   registered, always equal to |grant
//   grant_timeout one-cycle pulse after a grant is revoked purely by the hold limit
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       grant_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       owner;
  logic [CNT_W-1:0] hold_cnt;

  logic [7:0] masked_req;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic       end_rel;
  logic       end_drop;
  logic       end_hold;
  logic       grant_end;

  // First set bit of v, scanning upward from start and wrapping 7 -> 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] k;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      k = start + 3'(i);
      if (!found && v[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  // While a grant is active the current owner is excluded, so one requester
  // can never win two grants in a row without an idle cycle in between.
  always_comb begin
    masked_req = req;
    if (state == GRANT) begin
      masked_req[owner] = 1'b0;
    end
    {pick_found, pick_idx} = rr_pick(masked_req, ptr);
  end

  assign end_rel   = rel;
  assign end_drop  = !req[owner];
  assign end_hold  = (hold_cnt == HOLD_LAST);
  assign grant_end = end_rel || end_drop || end_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      owner         <= 3'd0;
      hold_cnt      <= '0;
      grant         <= 8'd0;
      grant_valid   <= 1'b0;
      grant_timeout <= 1'b0;
    end else begin
      grant_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= GRANT;
            grant       <= 8'd1 << pick_idx;
            grant_valid <= 1'b1;
            owner       <= pick_idx;
            ptr         <= pick_idx + 3'd1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            // Pulse only when the hold limit alone ended the grant.
            grant_timeout <= end_hold && !end_rel && !end_drop;
            if (pick_found) begin
              grant       <= 8'd1 << pick_idx;
              grant_valid <= 1'b1;
              owner       <= pick_idx;
              ptr         <= pick_idx + 3'd1;
              hold_cnt    <= '0;
            end else begin
              state       <= IDLE;
              grant       <= 8'd0;
              grant_valid <= 1'b0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= 8'd0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
